// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and load/store share one memory, one transaction at a time.
// Optional define MEM_ARB_RR_EN selects round-robin arbitration; default is fixed data-over-fetch.
module mem_arbiter #(
   parameter  int unsigned ADDR_W  = 64,
   parameter  int unsigned DATA_W  = 64,
   parameter  int unsigned TIMEOUT = 255,
   localparam int unsigned STRB_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [STRB_W-1:0] d_wstrb,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned WD_W = 16;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   logic [0:0]        state, state_nxt;
   logic              owner, owner_nxt;
   logic              wr, wr_nxt;
   logic [WD_W-1:0]   wd, wd_nxt;
   logic              pick_d;
   logic [DATA_W-1:0] resp_data;

   logic              if_gnt_nxt, if_rvalid_nxt, if_err_nxt;
   logic [DATA_W-1:0] if_rdata_nxt;
   logic              d_gnt_nxt, d_rvalid_nxt, d_err_nxt;
   logic [DATA_W-1:0] d_rdata_nxt;
   logic              mem_req_nxt, mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;
   logic [STRB_W-1:0] mem_wstrb_nxt;

`ifdef MEM_ARB_RR_EN
   // last_d = 0 means fetch was granted last, so data wins the first contention
   logic last_d, last_d_nxt;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      wr_nxt        = wr;
      wd_nxt        = wd;
      pick_d        = 1'b0;
      resp_data     = '0;
      if_gnt_nxt    = 1'b0;
      if_rvalid_nxt = 1'b0;
      if_err_nxt    = 1'b0;
      if_rdata_nxt  = if_rdata;
      d_gnt_nxt     = 1'b0;
      d_rvalid_nxt  = 1'b0;
      d_err_nxt     = 1'b0;
      d_rdata_nxt   = d_rdata;
      mem_req_nxt   = 1'b0;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_wstrb_nxt = mem_wstrb;
`ifdef MEM_ARB_RR_EN
      last_d_nxt    = last_d;
`endif

      case (state)
         ST_IDLE: begin
`ifdef MEM_ARB_RR_EN
            pick_d = d_req && (!if_req || !last_d);
`else
            pick_d = d_req;
`endif
            if (if_req || d_req) begin
               state_nxt   = ST_BUSY;
               wd_nxt      = '0;
               mem_req_nxt = 1'b1;
`ifdef MEM_ARB_RR_EN
               last_d_nxt  = pick_d;
`endif
               if (pick_d) begin
                  owner_nxt     = OWN_D;
                  wr_nxt        = d_we;
                  d_gnt_nxt     = 1'b1;
                  mem_we_nxt    = d_we;
                  mem_addr_nxt  = d_addr;
                  mem_wdata_nxt = d_we ? d_wdata : '0;
                  mem_wstrb_nxt = d_we ? d_wstrb : '0;
               end else begin
                  owner_nxt     = OWN_IF;
                  wr_nxt        = 1'b0;
                  if_gnt_nxt    = 1'b1;
                  mem_we_nxt    = 1'b0;
                  mem_addr_nxt  = if_addr;
                  mem_wdata_nxt = '0;
                  mem_wstrb_nxt = '0;
               end
            end
         end

         ST_BUSY: begin
            // An ack in the expiry cycle takes precedence over the timeout
            if (mem_ack || (wd == WD_W'(TIMEOUT))) begin
               state_nxt = ST_IDLE;
               resp_data = (mem_ack && !wr) ? mem_rdata : '0;
               if (owner == OWN_D) begin
                  d_rvalid_nxt = 1'b1;
                  d_err_nxt    = !mem_ack;
                  d_rdata_nxt  = resp_data;
               end else begin
                  if_rvalid_nxt = 1'b1;
                  if_err_nxt    = !mem_ack;
                  if_rdata_nxt  = resp_data;
               end
            end else begin
               wd_nxt = wd + WD_W'(1);
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         owner     <= OWN_IF;
         wr        <= 1'b0;
         wd        <= '0;
         if_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         if_err    <= 1'b0;
         if_rdata  <= '0;
         d_gnt     <= 1'b0;
         d_rvalid  <= 1'b0;
         d_err     <= 1'b0;
         d_rdata   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
`ifdef MEM_ARB_RR_EN
         last_d    <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         wr        <= wr_nxt;
         wd        <= wd_nxt;
         if_gnt    <= if_gnt_nxt;
         if_rvalid <= if_rvalid_nxt;
         if_err    <= if_err_nxt;
         if_rdata  <= if_rdata_nxt;
         d_gnt     <= d_gnt_nxt;
         d_rvalid  <= d_rvalid_nxt;
         d_err     <= d_err_nxt;
         d_rdata   <= d_rdata_nxt;
         mem_req   <= mem_req_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         mem_wstrb <= mem_wstrb_nxt;
`ifdef MEM_ARB_RR_EN
         last_d    <= last_d_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle-vector bench for mem_arbiter (default fixed-priority build, TIMEOUT = 4).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we, mem_ack;
   logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [7:0]  d_wstrb;
   logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we;
   logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [7:0]  mem_wstrb;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // f = {if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we}
   typedef struct {
      logic        ifr;
      logic [63:0] ia;
      logic        dr, dwe;
      logic [63:0] da, wd;
      logic [7:0]  ws;
      logic        ack;
      logic [63:0] mrd;
      logic [7:0]  f;
      logic [63:0] erd, ea;
      logic [7:0]  ews;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic ifr, input logic [63:0] ia, input logic dr, input logic dwe,
                               input logic [63:0] da, input logic [63:0] wd, input logic [7:0] ws,
                               input logic ack, input logic [63:0] mrd, input logic [7:0] f,
                               input logic [63:0] erd, input logic [63:0] ea, input logic [7:0] ews);
      vec_t v;
      v.ifr = ifr; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.wd = wd; v.ws = ws;
      v.ack = ack; v.mrd = mrd; v.f = f; v.erd = erd; v.ea = ea; v.ews = ews;
      return v;
   endfunction

   function automatic vec_t quiet(input logic ack, input logic [63:0] mrd, input logic [7:0] f,
                                  input logic [63:0] erd);
      return mk(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, ack, mrd, f, erd, 64'h0, 8'h0);
   endfunction

   task automatic check_vec(input int idx, input vec_t v);
      logic bad;
      bad = ({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req} !== v.f[7:1]);
      if (v.f[6] && (if_rdata !== v.erd)) bad = 1'b1;
      if (v.f[3] && (d_rdata !== v.erd)) bad = 1'b1;
      if (v.f[1]) begin
         if (mem_we !== v.f[0] || mem_addr !== v.ea || mem_wstrb !== v.ews) bad = 1'b1;
         if (v.f[0] && (mem_wdata !== v.wd)) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
         n_bad++;
         $display("FAIL vec%0d: got flags=%b we=%b addr=%h ws=%h wd=%h ird=%h drd=%h; want flags=%b rd=%h addr=%h ws=%h",
                  idx, {if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we},
                  mem_we, mem_addr, mem_wstrb, mem_wdata, if_rdata, d_rdata, v.f, v.erd, v.ea, v.ews);
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   function automatic logic [63:0] all_outs_or();
      return {56'h0, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we}
             | if_rdata | d_rdata | mem_addr | mem_wdata | {56'h0, mem_wstrb};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic got;
      reset = 1'b0;
      if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; mem_rdata = 0;

      // Single fetch, ack two cycles after mem_req
      vecs.push_back(mk(1, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 8'b1000_0010, 0, 64'h8000_0000, 8'h00));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(1, 64'h13, 8'b0100_0000, 64'h13));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      // Contention: data write wins, fetch waits until after d_rvalid
      vecs.push_back(mk(1, 64'h8000_0040, 1, 1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 0, 0,
                        8'b0001_0011, 0, 64'h8000_1000, 8'h0F));
      vecs.push_back(mk(1, 64'h8000_0040, 0, 0, 0, 0, 0, 0, 0, 8'b0, 0, 0, 0));
      vecs.push_back(mk(1, 64'h8000_0040, 0, 0, 0, 0, 0, 1, 64'h1234, 8'b0000_1000, 64'h0, 0, 0));
      vecs.push_back(mk(1, 64'h8000_0040, 0, 0, 0, 0, 0, 0, 0, 8'b1000_0010, 0, 64'h8000_0040, 8'h00));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(1, 64'h93, 8'b0100_0000, 64'h93));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      // Data read with no ack: timeout response five cycles after grant, strobes forced to 0
      vecs.push_back(mk(0, 0, 1, 0, 64'h100, 64'h0, 8'hFF, 0, 0, 8'b0001_0010, 0, 64'h100, 8'h00));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(0, 0, 8'b0000_1100, 64'h0));
      vecs.push_back(quiet(1, 64'hAA, 8'b0, 0));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      // Ack in the expiry cycle wins; a data request raised and dropped during BUSY is never granted
      vecs.push_back(mk(1, 64'h200, 0, 0, 0, 0, 0, 0, 0, 8'b1000_0010, 0, 64'h200, 8'h00));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 64'h999, 0, 0, 0, 0, 8'b0, 0, 0, 0));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(1, 64'h55, 8'b0100_0000, 64'h55));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      // Plain data read
      vecs.push_back(mk(0, 0, 1, 0, 64'h300, 0, 8'h00, 0, 0, 8'b0001_0010, 0, 64'h300, 8'h00));
      vecs.push_back(quiet(0, 0, 8'b0, 0));
      vecs.push_back(quiet(1, 64'hCAFE, 8'b0000_1000, 64'hCAFE));
      vecs.push_back(quiet(0, 0, 8'b0, 0));

      repeat (2) @(posedge clk);
      #1 chk("reset_outputs", all_outs_or(), 64'h0);
      @(negedge clk) reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         if_req = vecs[i].ifr; if_addr = vecs[i].ia;
         d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da;
         d_wdata = vecs[i].wd; d_wstrb = vecs[i].ws;
         mem_ack = vecs[i].ack; mem_rdata = vecs[i].mrd;
         @(posedge clk);
         #1 check_vec(i, vecs[i]);
      end

      // Reset while BUSY, then a late ack must be ignored
      @(negedge clk);
      if_req = 1'b1; if_addr = 64'h500;
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk);
         #1 got = if_gnt;
      end
      chk("gnt_before_reset", {63'h0, got}, 64'h1);
      @(negedge clk) if_req = 1'b0;
      @(negedge clk) reset = 1'b0;
      #1 chk("outputs_in_reset", all_outs_or(), 64'h0);
      @(negedge clk);
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 64'h77;
      @(posedge clk);
      #1 chk("late_ack_no_rvalid", {62'h0, if_rvalid, d_rvalid}, 64'h0);
      @(negedge clk);
      mem_ack = 1'b0; if_req = 1'b1; if_addr = 64'h600;
      @(posedge clk);
      #1 begin
         chk("regrant_gnt", {62'h0, if_gnt, mem_req}, 64'h3);
         chk("regrant_addr", mem_addr, 64'h600);
      end
      @(negedge clk) if_req = 1'b0;
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
